// File: rtl/cmd_bus_pkg.sv
// Shared command-bus definitions: register offsets, opcodes, FSM encoding and bus widths.
// No logic, so no latency or flow-control behaviour of its own.
package cmd_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam logic [7:0] REG_CMD       = 8'h00;
  localparam logic [7:0] REG_HIGH_TIME = 8'h01;
  localparam logic [7:0] REG_LOW_TIME  = 8'h02;
  localparam logic [7:0] REG_CYCLES    = 8'h03;
  localparam logic [7:0] REG_DONE      = 8'h04;

  localparam logic [3:0] OP_RESET = 4'd0;
  localparam logic [3:0] OP_CONST = 4'd1;
  localparam logic [3:0] OP_WAVE  = 4'd2;
  localparam logic [3:0] OP_STOP  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONST   = 2'd1,
    ST_WAVE_HI = 2'd2,
    ST_WAVE_LO = 2'd3
  } pin_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              en;
    logic              wr;
    logic              rd;
  } cmd_req_t;

  // A programmed phase length of zero still lasts one cycle.
  function automatic logic [DATA_W-1:0] min1(input logic [DATA_W-1:0] v);
    return (v == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : v;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// 32-bit loadable down-counter timing the wave phases; terminal flags a value of 1.
// Load/clear take effect on the next edge; no backpressure, clear beats load beats decrement.
module phase_counter
  import cmd_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic [DATA_W-1:0] value_o,
  output logic              terminal_o
);

  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o    = cnt_q;
  assign terminal_o = (cnt_q == {{(DATA_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/cmd_pin_responder.sv
// Command-bus driven pin generator (idle/const/square wave); commands and reads respond one cycle later, never stalls.
// Optional read path enabled by CMD_PIN_READBACK_EN; without it rd_data/rd_valid are tied to 0.
module cmd_pin_responder
  import cmd_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0100
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cmd_bus_addr,
  input  logic [DATA_W-1:0] cmd_bus_data,
  input  logic              cmd_bus_en,
  input  logic              cmd_bus_wr,
  input  logic              cmd_bus_rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              pin_out,
  output logic              pin_oe
);

  cmd_req_t req;
  assign req = '{addr: cmd_bus_addr, data: cmd_bus_data,
                 en: cmd_bus_en, wr: cmd_bus_wr, rd: cmd_bus_rd};

  logic       sel;
  logic       wr_acc;
  logic       cmd_wr;
  logic [7:0] reg_off;
  logic [3:0] opcode;

  assign sel     = req.en && (req.addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign wr_acc  = sel && req.wr;
  assign reg_off = req.addr[7:0];
  assign opcode  = req.data[3:0];
  assign cmd_wr  = wr_acc && (reg_off == REG_CMD);

  pin_state_e        state_q, state_d;
  logic              level_q, level_d;
  logic              pin_out_q, pin_out_d;
  logic              pin_oe_q, pin_oe_d;
  logic [DATA_W-1:0] done_q, done_d, done_inc;
  logic [DATA_W-1:0] high_time_q, low_time_q, cycles_q;

  logic              cnt_clr, cnt_load, cnt_dec, cnt_term;
  logic [DATA_W-1:0] cnt_load_val;
  logic [DATA_W-1:0] unused_cnt_value;

  phase_counter u_phase_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .value_o    (unused_cnt_value),
    .terminal_o (cnt_term)
  );

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    done_d       = done_q;
    done_inc     = done_q + {{(DATA_W-1){1'b0}}, 1'b1};
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;

    // Free-running wave sequencing; a valid command below overrides it for this cycle.
    case (state_q)
      ST_WAVE_HI: begin
        cnt_dec = 1'b1;
        if (cnt_term) begin
          state_d      = ST_WAVE_LO;
          cnt_load     = 1'b1;
          cnt_load_val = min1(low_time_q);
        end
      end
      ST_WAVE_LO: begin
        cnt_dec = 1'b1;
        if (cnt_term) begin
          done_d = done_inc;
          if ((cycles_q != '0) && (done_inc == cycles_q)) begin
            state_d = ST_CONST;
            level_d = 1'b0;
          end else begin
            state_d      = ST_WAVE_HI;
            cnt_load     = 1'b1;
            cnt_load_val = min1(high_time_q);
          end
        end
      end
      default: ;
    endcase

    if (cmd_wr) begin
      case (opcode)
        OP_RESET: begin
          state_d  = ST_IDLE;
          done_d   = '0;
          cnt_clr  = 1'b1;
          cnt_load = 1'b0;
          cnt_dec  = 1'b0;
        end
        OP_CONST: begin
          state_d  = ST_CONST;
          level_d  = req.data[4];
          done_d   = done_q;
          cnt_load = 1'b0;
          cnt_dec  = 1'b0;
        end
        OP_WAVE: begin
          state_d      = ST_WAVE_HI;
          done_d       = '0;
          cnt_load     = 1'b1;
          cnt_load_val = min1(high_time_q);
        end
        OP_STOP: begin
          state_d  = ST_CONST;
          level_d  = pin_out_q;
          done_d   = done_q;
          cnt_load = 1'b0;
          cnt_dec  = 1'b0;
        end
        default: ;
      endcase
    end

    pin_oe_d  = (state_d != ST_IDLE);
    pin_out_d = (state_d == ST_WAVE_HI) || ((state_d == ST_CONST) && level_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      level_q   <= 1'b0;
      done_q    <= '0;
      pin_out_q <= 1'b0;
      pin_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      done_q    <= done_d;
      pin_out_q <= pin_out_d;
      pin_oe_q  <= pin_oe_d;
    end
  end

  // Config changes only reach the pin at the next counter load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_time_q <= '0;
      low_time_q  <= '0;
      cycles_q    <= '0;
    end else if (wr_acc) begin
      case (reg_off)
        REG_HIGH_TIME: high_time_q <= req.data;
        REG_LOW_TIME:  low_time_q  <= req.data;
        REG_CYCLES:    cycles_q    <= req.data;
        default: ;
      endcase
    end
  end

  assign pin_out = pin_out_q;
  assign pin_oe  = pin_oe_q;

`ifdef CMD_PIN_READBACK_EN
  logic              rd_acc;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_mux;

  assign rd_acc = sel && req.rd && !req.wr;

  always_comb begin
    rd_mux = '0;
    case (reg_off)
      REG_HIGH_TIME: rd_mux = high_time_q;
      REG_LOW_TIME:  rd_mux = low_time_q;
      REG_CYCLES:    rd_mux = cycles_q;
      REG_DONE:      rd_mux = done_q;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      rd_data_q  <= rd_acc ? rd_mux : '0;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_rd;
  assign unused_rd = req.rd;
  assign rd_data   = '0;
  assign rd_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_pin_responder.sv
// Randomized and directed bench for cmd_pin_responder against a phase-length behavioural model.
module tb_cmd_pin_responder;

  logic        clk;
  logic        rst;
  logic [15:0] cmd_bus_addr;
  logic [31:0] cmd_bus_data;
  logic        cmd_bus_en, cmd_bus_wr, cmd_bus_rd;
  logic [31:0] rd_data;
  logic        rd_valid, pin_out, pin_oe;

  cmd_pin_responder #(.BASE_ADDR(16'h0100)) dut (
    .clk(clk), .rst(rst),
    .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data),
    .cmd_bus_en(cmd_bus_en), .cmd_bus_wr(cmd_bus_wr), .cmd_bus_rd(cmd_bus_rd),
    .rd_data(rd_data), .rd_valid(rd_valid), .pin_out(pin_out), .pin_oe(pin_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CMD_PIN_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  int vecs = 0;
  int miscmp = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 constant, 2 wave; rem = cycles left in the current wave phase.
  int          m_mode;
  bit          m_level, m_high;
  longint      m_rem;
  logic [31:0] m_hi, m_lo, m_cyc, m_done;
  bit          exp_out, exp_oe, exp_rdv;
  logic [31:0] exp_rdd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint len(input logic [31:0] v);
    return (v == 0) ? 64'd1 : longint'(v);
  endfunction

  task automatic model_pins();
    exp_oe  = (m_mode != 0);
    exp_out = (m_mode == 2) ? m_high : ((m_mode == 1) ? m_level : 1'b0);
  endtask

  task automatic model_reset();
    m_mode = 0; m_level = 0; m_high = 0; m_rem = 0;
    m_hi = 0; m_lo = 0; m_cyc = 0; m_done = 0;
    exp_rdv = 0; exp_rdd = 0;
    model_pins();
  endtask

  task automatic model_step(input bit en, input bit wr, input bit rd,
                            input logic [15:0] a, input logic [31:0] d);
    bit sel, wrc, cmd, cur_out;
    logic [7:0] off;
    logic [3:0] op;
    sel = en && (a[15:8] == 8'h01);
    off = a[7:0];
    op  = d[3:0];
    wrc = sel && wr;
    cur_out = exp_out;
    exp_rdv = 0;
    exp_rdd = 0;
    if (RB && sel && rd && !wr) begin
      exp_rdv = 1;
      case (off)
        8'h01: exp_rdd = m_hi;
        8'h02: exp_rdd = m_lo;
        8'h03: exp_rdd = m_cyc;
        8'h04: exp_rdd = m_done;
        default: exp_rdd = 0;
      endcase
    end
    cmd = wrc && (off == 8'h00) && (op <= 4'd3);
    if (!cmd && m_mode == 2) begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_high) begin
          m_high = 0; m_rem = len(m_lo);
        end else begin
          m_done = m_done + 1;
          if (m_cyc != 0 && m_done == m_cyc) begin
            m_mode = 1; m_level = 0;
          end else begin
            m_high = 1; m_rem = len(m_hi);
          end
        end
      end
    end
    if (cmd) begin
      case (op)
        4'd0: begin m_mode = 0; m_done = 0; end
        4'd1: begin m_mode = 1; m_level = d[4]; end
        4'd2: begin m_mode = 2; m_high = 1; m_rem = len(m_hi); m_done = 0; end
        default: begin m_mode = 1; m_level = cur_out; end
      endcase
    end
    if (wrc) begin
      case (off)
        8'h01: m_hi  = d;
        8'h02: m_lo  = d;
        8'h03: m_cyc = d;
        default: ;
      endcase
    end
    model_pins();
  endtask

  // One bus cycle: drive, clock, advance model, return at the following falling edge.
  task automatic cyc(input bit en, input bit wr, input bit rd,
                     input logic [15:0] a, input logic [31:0] d);
    cmd_bus_en = en; cmd_bus_wr = wr; cmd_bus_rd = rd;
    cmd_bus_addr = a; cmd_bus_data = d;
    @(posedge clk);
    model_step(en, wr, rd, a, d);
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    cyc(1, 1, 0, a, d);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 16'h0000, 32'h0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("pin_out", {31'b0, pin_out}, {31'b0, exp_out});
        chk("pin_oe", {31'b0, pin_oe}, {31'b0, exp_oe});
        chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rdv});
        chk("rd_data", rd_data, exp_rdd);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_seq [6];
    logic [31:0] d;
    logic [7:0] blk, off;
    int r;

    rst = 1'b1;
    cmd_bus_en = 0; cmd_bus_wr = 0; cmd_bus_rd = 0;
    cmd_bus_addr = 0; cmd_bus_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_pin_out", {31'b0, pin_out}, 32'd0);
    chk("reset_pin_oe", {31'b0, pin_oe}, 32'd0);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Wave shape: HIGH=3, LOW=2 -> 1,1,1,0,0,1 after the command.
    bus_wr(16'h0101, 32'd3);
    bus_wr(16'h0102, 32'd2);
    bus_wr(16'h0103, 32'd0);
    bus_wr(16'h0100, 32'd2);
    exp_seq = '{1, 1, 1, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) idle();
      chk("wave_shape", {31'b0, pin_out}, {31'b0, exp_seq[i]});
    end
    chk("wave_done_model", m_done, 32'd1);

    // Bounded run: two 1/1 periods then constant low.
    bus_wr(16'h0103, 32'd2);
    bus_wr(16'h0101, 32'd1);
    bus_wr(16'h0102, 32'd1);
    bus_wr(16'h0100, 32'd2);
    exp_seq = '{1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) idle();
      chk("bounded_out", {31'b0, pin_out}, {31'b0, exp_seq[i]});
      chk("bounded_oe", {31'b0, pin_oe}, 32'd1);
    end
    cyc(1, 0, 1, 16'h0104, 32'h0);
    chk("done_rd_valid", {31'b0, rd_valid}, RB ? 32'd1 : 32'd0);
    chk("done_rd_data", rd_data, RB ? 32'd2 : 32'd0);

    // Constant-high then reset command.
    bus_wr(16'h0100, 32'h11);
    chk("const_out", {31'b0, pin_out}, 32'd1);
    chk("const_oe", {31'b0, pin_oe}, 32'd1);
    bus_wr(16'h0100, 32'h0);
    chk("rstcmd_out", {31'b0, pin_out}, 32'd0);
    chk("rstcmd_oe", {31'b0, pin_oe}, 32'd0);

    // Foreign block ignored; rd+wr: write wins, no response.
    bus_wr(16'h0103, 32'd0);
    bus_wr(16'h0102, 32'd1);
    bus_wr(16'h0101, 32'd2);
    bus_wr(16'h0201, 32'd5);
    cyc(1, 1, 1, 16'h0101, 32'd3);
    chk("rdwr_no_valid", {31'b0, rd_valid}, 32'd0);
    bus_wr(16'h0100, 32'd2);
    exp_seq = '{1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) idle();
      chk("rdwr_wave", {31'b0, pin_out}, {31'b0, exp_seq[i]});
    end

    // Asynchronous reset in the middle of a high phase.
    bus_wr(16'h0101, 32'd4);
    bus_wr(16'h0100, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", {31'b0, pin_out}, 32'd0);
    chk("async_rst_oe", {31'b0, pin_oe}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 1, 16'h0101, 32'h0);
    chk("post_rst_ht_valid", {31'b0, rd_valid}, RB ? 32'd1 : 32'd0);
    chk("post_rst_ht_data", rd_data, 32'd0);
    bus_wr(16'h0100, 32'h11);
    chk("first_write_after_rst", {31'b0, pin_out}, 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 7);
      blk = (r == 0) ? 8'h02 : ((r == 1) ? 8'($urandom) : 8'h01);
      off = 8'($urandom_range(0, 6));
      d = $urandom;
      if (off == 8'h00) d[3:0] = 4'($urandom_range(0, 5));
      else if (off <= 8'h03) d = $urandom_range(0, 4);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, {blk, off}, d);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
